// File: rtl/qspi_sel_switcher_pkg.sv
// Shared types and constants for the QSPI select switcher.
package qspi_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam logic QSPI_SEL_XIP    = 1'b0;
  localparam logic QSPI_SEL_NORMAL = 1'b1;

endpackage

// File: rtl/qspi_sel_switcher_if.sv
// Software switch-request handshake between requester and qspi_sel_switcher.
interface qspi_sel_switcher_if;
  logic sel_req_valid;
  logic sel_req_target;
  logic sel_req_ready;
  logic sel_done;
  logic sel_err;

  modport master (
    output sel_req_valid, sel_req_target,
    input  sel_req_ready, sel_done, sel_err
  );

  modport slave (
    input  sel_req_valid, sel_req_target,
    output sel_req_ready, sel_done, sel_err
  );
endinterface

// File: rtl/qspi_sel_switcher_quiet_detect.sv
// Counts consecutive cycles with both QSPI controllers idle on their pins.
module qspi_quiet_detect #(
  parameter int unsigned QUIET_CYCLES = 4
) (
  input  logic ext_spi_clk,
  input  logic ext_spi_resetn,
  input  logic clear,
  input  logic enable,
  input  logic qspi_xip_ss_o,
  input  logic qspi_xip_ck_o,
  input  logic qspi_ss_o,
  input  logic qspi_ck_o,
  output logic quiet_done
);

  localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] CNT_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [QW-1:0] CNT_FULL = QW'(QUIET_CYCLES);

  logic          quiet;
  logic [QW-1:0] quiet_cnt;

  assign quiet = qspi_xip_ss_o & qspi_ss_o & ~qspi_xip_ck_o & ~qspi_ck_o;

  always_ff @(posedge ext_spi_clk or negedge ext_spi_resetn) begin
    if (!ext_spi_resetn) begin
      quiet_cnt <= '0;
    end else if (clear) begin
      quiet_cnt <= '0;
    end else if (enable) begin
      if (!quiet)
        quiet_cnt <= '0;
      else if (quiet_cnt != CNT_FULL)
        quiet_cnt <= quiet_cnt + QW'(1);
    end
  end

  // Completes on the cycle that would make the count reach QUIET_CYCLES.
  assign quiet_done = enable & quiet & (quiet_cnt == CNT_LAST);

endmodule

// File: rtl/qspi_sel_switcher.sv
// Switches the shield-adaptor QSPI mux select only after both controllers go quiet.
module qspi_sel_switcher
  import qspi_sel_pkg::*;
#(
  parameter int unsigned QUIET_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic        RESET_SEL      = QSPI_SEL_XIP
) (
  input  logic                ext_spi_clk,
  input  logic                ext_spi_resetn,
  qspi_sel_switcher_if.slave  req,
  input  logic                qspi_xip_ss_o,
  input  logic                qspi_xip_ck_o,
  input  logic                qspi_ss_o,
  input  logic                qspi_ck_o,
  output logic                xip_hold,
  output logic                qspi_sel,
  output logic [1:0]          state_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic          target_q;
  logic [TW-1:0] tmo_cnt;
  logic          done_q;
  logic          err_q;
  logic          ready;
  logic          quiet_done;

  assign ready             = (state == IDLE);
  assign req.sel_req_ready = ready;
  assign req.sel_done      = done_q;
  assign req.sel_err       = err_q;
  assign state_o           = state;

  qspi_quiet_detect #(
    .QUIET_CYCLES (QUIET_CYCLES)
  ) u_quiet (
    .ext_spi_clk    (ext_spi_clk),
    .ext_spi_resetn (ext_spi_resetn),
    .clear          (state != DRAIN),
    .enable         (state == DRAIN),
    .qspi_xip_ss_o  (qspi_xip_ss_o),
    .qspi_xip_ck_o  (qspi_xip_ck_o),
    .qspi_ss_o      (qspi_ss_o),
    .qspi_ck_o      (qspi_ck_o),
    .quiet_done     (quiet_done)
  );

  always_ff @(posedge ext_spi_clk or negedge ext_spi_resetn) begin
    if (!ext_spi_resetn) begin
      state    <= IDLE;
      qspi_sel <= RESET_SEL;
      target_q <= RESET_SEL;
      xip_hold <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (req.sel_req_valid && ready) begin
            target_q <= req.sel_req_target;
            if (req.sel_req_target == qspi_sel) begin
              done_q <= 1'b1;
            end else begin
              xip_hold <= 1'b1;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (tmo_cnt != TMO_LAST)
            tmo_cnt <= tmo_cnt + TW'(1);
          // Quiet completion takes priority over a coincident timeout.
          if (quiet_done) begin
            qspi_sel <= target_q;
            state    <= SWITCH;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q    <= 1'b1;
            xip_hold <= 1'b0;
            state    <= IDLE;
          end
        end
        SWITCH: begin
          xip_hold <= 1'b0;
          done_q   <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          xip_hold <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_sel_switcher.sv
// Directed checks of qspi_sel_switcher with QUIET_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_qspi_sel_switcher;

  logic       clk;
  logic       rst_n;
  logic       xip_ss, xip_ck, ss, ck;
  logic       xip_hold;
  logic       qspi_sel;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;

  qspi_sel_switcher_if req_if ();

  qspi_sel_switcher #(
    .QUIET_CYCLES   (4),
    .TIMEOUT_CYCLES (16),
    .RESET_SEL      (1'b0)
  ) dut (
    .ext_spi_clk    (clk),
    .ext_spi_resetn (rst_n),
    .req            (req_if),
    .qspi_xip_ss_o  (xip_ss),
    .qspi_xip_ck_o  (xip_ck),
    .qspi_ss_o      (ss),
    .qspi_ck_o      (ck),
    .xip_hold       (xip_hold),
    .qspi_sel       (qspi_sel),
    .state_o        (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic sel);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_sel"},   32'(qspi_sel), 32'(sel));
    check({tag, "_hold"},  32'(xip_hold), 32'd0);
    check({tag, "_ready"}, 32'(req_if.sel_req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    req_if.sel_req_valid  = 1'b0;
    req_if.sel_req_target = 1'b0;
    xip_ss = 1'b1; xip_ck = 1'b0; ss = 1'b1; ck = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst", 1'b0);
    check("rst_done", 32'(req_if.sel_done), 32'd0);
    check("rst_err",  32'(req_if.sel_err),  32'd0);
    #9 rst_n = 1'b1;
    tick();

    // No-op: target equals current select
    req_if.sel_req_valid = 1'b1; req_if.sel_req_target = 1'b0;
    tick();
    req_if.sel_req_valid = 1'b0;
    check("noop_done", 32'(req_if.sel_done), 32'd1);
    check_idle("noop", 1'b0);
    tick();
    check("noop_done_clr", 32'(req_if.sel_done), 32'd0);

    // Quiet-bus switch to normal controller
    req_if.sel_req_valid = 1'b1; req_if.sel_req_target = 1'b1;
    tick();
    req_if.sel_req_valid = 1'b0;
    check("sw_hold_n",  32'(xip_hold), 32'd1);
    check("sw_state_n", 32'(state_o), 32'd1);
    check("sw_ready_n", 32'(req_if.sel_req_ready), 32'd0);
    tick(); tick(); tick();
    check("sw_sel_n3",  32'(qspi_sel), 32'd0);
    check("sw_done_n3", 32'(req_if.sel_done), 32'd0);
    tick();
    check("sw_sel_n4",   32'(qspi_sel), 32'd1);
    check("sw_state_n4", 32'(state_o), 32'd2);
    check("sw_hold_n4",  32'(xip_hold), 32'd1);
    check("sw_done_n4",  32'(req_if.sel_done), 32'd0);
    tick();
    check("sw_done_n5", 32'(req_if.sel_done), 32'd1);
    check("sw_err_n5",  32'(req_if.sel_err), 32'd0);
    check_idle("sw_n5", 1'b1);
    tick();
    check("sw_done_n6", 32'(req_if.sel_done), 32'd0);

    // Asynchronous reset in the middle of DRAIN
    req_if.sel_req_valid = 1'b1; req_if.sel_req_target = 1'b0;
    tick();
    req_if.sel_req_valid = 1'b0;
    tick(); tick();
    check("ar_state_pre", 32'(state_o), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_idle("ar", 1'b0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ar_done", 32'(req_if.sel_done), 32'd0);
      check("ar_err",  32'(req_if.sel_err), 32'd0);
    end
    check_idle("ar_post", 1'b0);

    // XIP slave select busy mid-DRAIN, plus an ignored opposite request
    req_if.sel_req_valid = 1'b1; req_if.sel_req_target = 1'b1;
    tick();                                   // edge N
    req_if.sel_req_valid = 1'b1; req_if.sel_req_target = 1'b0;
    tick();                                   // N+1
    req_if.sel_req_valid = 1'b0;
    tick();                                   // N+2
    xip_ss = 1'b0;
    for (int i = 0; i < 10; i++) tick();      // N+3 .. N+12
    check("gl_state_n12", 32'(state_o), 32'd1);
    check("gl_sel_n12",   32'(qspi_sel), 32'd0);
    xip_ss = 1'b1;
    tick(); tick(); tick();                   // N+15
    check("gl_sel_n15", 32'(qspi_sel), 32'd0);
    tick();                                   // N+16: quiet wins over timeout
    check("gl_sel_n16",   32'(qspi_sel), 32'd1);
    check("gl_state_n16", 32'(state_o), 32'd2);
    check("gl_err_n16",   32'(req_if.sel_err), 32'd0);
    tick();
    check("gl_done_n17", 32'(req_if.sel_done), 32'd1);
    check_idle("gl_n17", 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gl_done_after", 32'(req_if.sel_done), 32'd0);
      check("gl_sel_after",  32'(qspi_sel), 32'd1);
    end

    // Timeout: normal controller slave select held low
    ss = 1'b0;
    req_if.sel_req_valid = 1'b1; req_if.sel_req_target = 1'b0;
    tick();
    req_if.sel_req_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_err_n15",   32'(req_if.sel_err), 32'd0);
    check("to_state_n15", 32'(state_o), 32'd1);
    tick();
    check("to_err_n16",  32'(req_if.sel_err), 32'd1);
    check("to_done_n16", 32'(req_if.sel_done), 32'd0);
    check_idle("to_n16", 1'b1);
    tick();
    check("to_err_n17", 32'(req_if.sel_err), 32'd0);
    ss = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qspi_sel_switcher.md
Name: qspi_sel_switcher

Overview:
- Generates the qspi_sel select for the QSPI pin mux in the shield adaptor. The mux chooses between the XIP read-only controller and the normal read-write controller.
- Sits directly upstream of the shield adaptor, on the ext_spi_clk domain.
- Accepts a software switch request and holds off the XIP path while it switches.
- Changes qspi_sel only after both controllers have been idle for a programmable number of cycles, so the flash never sees a truncated transaction.

Parameters:
- QUIET_CYCLES, 4: consecutive idle cycles required before switching. Must be at least 1.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in DRAIN before the request is aborted. Must be greater than QUIET_CYCLES.
- RESET_SEL, 0: qspi_sel value at reset. 0 = XIP controller, 1 = normal controller.

Ports:
- ext_spi_clk  in  1  clock; the QSPI controllers' SPI-side outputs are synchronous to it
- ext_spi_resetn  in  1  asynchronous, active-low reset
- sel_req_valid  in  1  switch request; held until accepted
- sel_req_target  in  1  requested qspi_sel value
- sel_req_ready  out  1  high in IDLE
- sel_done  out  1  one-cycle pulse: switch complete, or no-op complete
- sel_err  out  1  one-cycle pulse: request timed out, qspi_sel unchanged
- qspi_xip_ss_o  in  1  XIP controller slave select, active low
- qspi_xip_ck_o  in  1  XIP controller clock output
- qspi_ss_o  in  1  normal controller slave select, active low
- qspi_ck_o  in  1  normal controller clock output
- xip_hold  out  1  stall request to the XIP bus front-end (no new transactions)
- qspi_sel  out  1  mux select to the shield adaptor, registered
- state_o  out  2  FSM state, debug

Behaviour:
- Clocking and reset:
  - Single clock ext_spi_clk.
  - Reset is asynchronous, active-low (ext_spi_resetn).
  - In reset: state=IDLE, qspi_sel=RESET_SEL, xip_hold=0, sel_done=0, sel_err=0, sel_req_ready=1, counters=0.
  - Reset mid-operation abandons the request and forces qspi_sel back to RESET_SEL.
- Quiet condition: quiet = qspi_xip_ss_o & qspi_ss_o & ~qspi_xip_ck_o & ~qspi_ck_o.
- Handshake:
  - Accept occurs on a rising edge with sel_req_valid & sel_req_ready.
  - sel_req_target is latched at accept.
  - sel_req_valid while not ready is ignored; it is not queued.
- IDLE (state_o=0):
  - sel_req_ready=1.
  - Accept with target == qspi_sel: sel_done pulses in the next cycle, no hold is applied, state stays IDLE.
  - Accept with target != qspi_sel: xip_hold<=1, quiet_cnt<=0, tmo_cnt<=0, go to DRAIN.
- DRAIN (state_o=1):
  - sel_req_ready=0; tmo_cnt increments every cycle.
  - quiet_cnt increments while quiet and clears to 0 on any non-quiet cycle.
  - When quiet and quiet_cnt == QUIET_CYCLES-1: qspi_sel<=target, go to SWITCH.
  - Else when tmo_cnt == TIMEOUT_CYCLES-1: sel_err<=1, xip_hold<=0, go to IDLE.
  - Quiet completion wins if both conditions are true on the same cycle.
- SWITCH (state_o=2):
  - One guard cycle with xip_hold still 1, so the mux output settles.
  - Next edge: xip_hold<=0, sel_done<=1, go to IDLE.
- Latency, uninterrupted quiet bus:
  - sel_done is high in the cycle after the (QUIET_CYCLES+1)th rising edge following the accept edge.
  - qspi_sel changes exactly one cycle before sel_done.
- Signal rules:
  - qspi_sel changes only on the DRAIN->SWITCH edge, or at reset.
  - sel_done and sel_err are never high together, and each is high for exactly one cycle.
  - state_o value 3 is unused; an illegal state recovers to IDLE with xip_hold=0.
- Widths:
  - quiet_cnt is $clog2(QUIET_CYCLES+1) bits; tmo_cnt is $clog2(TIMEOUT_CYCLES) bits.
  - Counters saturate and never wrap.

Decomposition:
- Shared package qspi_sel_pkg holds:
  - the state enum: IDLE=2'd0, DRAIN=2'd1, SWITCH=2'd2;
  - QSPI_SEL_XIP=1'b0 and QSPI_SEL_NORMAL=1'b1.
- One sub-module, qspi_quiet_detect: takes the four SPI pins plus clear and enable; outputs a quiet_done flag.
- The FSM and timeout logic stay in the top module.

Test Plan:
- Quiet bus, QUIET_CYCLES=4: accept target=1 at edge N -> xip_hold=1 from N; qspi_sel=1 after edge N+4; sel_done high after edge N+5; xip_hold=0 after N+5.
- Request target equal to the current qspi_sel=0 -> sel_done pulses the next cycle; xip_hold stays 0; qspi_sel stays 0.
- qspi_xip_ss_o goes low on the 3rd DRAIN cycle for 10 cycles -> quiet_cnt restarts; the switch completes 4 cycles after ss returns high.
- qspi_ss_o held low, TIMEOUT_CYCLES=16 -> sel_err pulses after edge N+16; qspi_sel unchanged; xip_hold=0; sel_req_ready=1.
- Assert ext_spi_resetn low during DRAIN, asynchronously mid-cycle -> immediately state=IDLE, qspi_sel=RESET_SEL, xip_hold=0; no sel_done or sel_err after release.
- sel_req_valid pulsed during DRAIN with the opposite target -> ignored; only the original request completes, with one sel_done.
